// File: rtl/access_sequencer_pkg.sv
// Shared widths and FSM encodings for the access sequencer and its memory-side interface.
package access_sequencer_pkg;

  localparam int unsigned DefAddrW = 15;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCntW  = 16;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t StIdle = 3'd0;
  localparam seq_state_t StReq  = 3'd1;
  localparam seq_state_t StWait = 3'd2;
  localparam seq_state_t StGap  = 3'd3;
  localparam seq_state_t StFin  = 3'd4;

  function automatic logic state_is_busy(seq_state_t st);
    return (st == StReq) || (st == StWait) || (st == StGap);
  endfunction

endpackage

// File: rtl/access_sequencer_if.sv
// Read port between the sequencer (master) and the memory hierarchy (slave).
interface access_sequencer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] address;
  logic              MemRead;
  logic [DATA_W-1:0] data;
  logic              DataReady;
  logic              HMbar;

  modport master (
    output address,
    output MemRead,
    input  data,
    input  DataReady,
    input  HMbar
  );

  modport slave (
    input  address,
    input  MemRead,
    output data,
    output DataReady,
    output HMbar
  );

endinterface

// File: rtl/access_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module access_sequencer_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/access_sequencer.sv
// Issues a run of consecutive word reads to the memory hierarchy, tallying hits/misses
// and summing the returned data.
module access_sequencer
  import access_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned START_ADDR   = 1024,
  parameter int unsigned NUM_ACCESSES = 8192,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  access_sequencer_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [DATA_W-1:0] data_sum
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              hit_flag_q, hit_flag_d;
  logic              terr_q, terr_d;
  logic              mr_q, busy_q, done_q;
  logic              clear_cnt, complete, hit_now;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    sum_d      = sum_q;
    hit_flag_d = hit_flag_q;
    terr_d     = terr_q;
    clear_cnt  = 1'b0;
    complete   = 1'b0;
    hit_now    = hit_flag_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          clear_cnt = 1'b1;
          sum_d     = '0;
          terr_d    = 1'b0;
          idx_d     = '0;
          addr_d    = ADDR_W'(START_ADDR);
          state_d   = StReq;
        end
      end
      StReq: begin
        // Hit/miss is judged on first presentation, before any refill can change it.
        hit_flag_d = mem.HMbar;
        hit_now    = mem.HMbar;
        wait_d     = '0;
        if (mem.DataReady) begin
          complete = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem.DataReady) begin
          complete = 1'b1;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = StFin;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StGap:   state_d = StReq;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (complete) begin
      sum_d = sum_q + mem.data;
      if (idx_q == CNT_W'(NUM_ACCESSES - 1)) begin
        state_d = StFin;
      end else begin
        idx_d   = idx_q + CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StGap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= ADDR_W'(START_ADDR);
      idx_q      <= '0;
      wait_q     <= '0;
      sum_q      <= '0;
      hit_flag_q <= 1'b0;
      terr_q     <= 1'b0;
      mr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      sum_q      <= sum_d;
      hit_flag_q <= hit_flag_d;
      terr_q     <= terr_d;
      mr_q       <= (state_d == StReq) || (state_d == StWait);
      busy_q     <= state_is_busy(state_d);
      done_q     <= (state_d == StFin);
    end
  end

  access_sequencer_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_cnt),
    .en_i    (complete && hit_now),
    .count_o (hit_count)
  );

  access_sequencer_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_cnt),
    .en_i    (complete && !hit_now),
    .count_o (miss_count)
  );

  assign mem.address = addr_q;
  assign mem.MemRead = mr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign data_sum    = sum_q;

endmodule

// File: tb/tb_access_sequencer.sv
// Directed bench: two sequencer instances with different start addresses, each driven by a
// small behavioural memory model.
module tb_access_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  always #5 clk = ~clk;

  access_sequencer_if #(.ADDR_W(15), .DATA_W(32)) ifa ();
  access_sequencer_if #(.ADDR_W(15), .DATA_W(32)) ifb ();

  logic        busy_a, done_a, terr_a, busy_b, done_b, terr_b;
  logic [15:0] hit_a, miss_a, hit_b, miss_b;
  logic [31:0] sum_a, sum_b;

  access_sequencer #(
    .ADDR_W(15), .DATA_W(32), .CNT_W(16), .START_ADDR(0), .NUM_ACCESSES(4), .TIMEOUT(8)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .mem         (ifa),
    .busy        (busy_a),
    .done        (done_a),
    .timeout_err (terr_a),
    .hit_count   (hit_a),
    .miss_count  (miss_a),
    .data_sum    (sum_a)
  );

  access_sequencer #(
    .ADDR_W(15), .DATA_W(32), .CNT_W(16), .START_ADDR('h7FFE), .NUM_ACCESSES(3), .TIMEOUT(8)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .mem         (ifb),
    .busy        (busy_b),
    .done        (done_b),
    .timeout_err (terr_b),
    .hit_count   (hit_b),
    .miss_count  (miss_b),
    .data_sum    (sum_b)
  );

  // Memory model A: one configurable miss address with a fixed stall, optional dead memory.
  logic        never_a    = 1'b0;
  logic        ff_mode_a  = 1'b0;
  logic [14:0] miss_addr_a = 15'h7FFF;
  int          delay_a    = 0;
  int          cyc_a      = 0;

  always @(posedge clk) cyc_a <= ifa.MemRead ? cyc_a + 1 : 0;

  assign ifa.HMbar     = (ifa.address != miss_addr_a);
  assign ifa.DataReady = ifa.MemRead && !never_a && (ifa.HMbar || (cyc_a >= delay_a));
  assign ifa.data      = ff_mode_a ? ((ifa.address < 15'd2) ? 32'hFFFF_FFFF : 32'h0)
                                   : (32'(ifa.address) + 32'd1);

  // Memory model B: all hits, or (stall mode) address 0x7FFF misses and never completes.
  logic stall_b = 1'b0;

  assign ifb.HMbar     = !(stall_b && (ifb.address == 15'h7FFF));
  assign ifb.DataReady = ifb.MemRead && ifb.HMbar;
  assign ifb.data      = 32'(ifb.address);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [14:0] addrs[$];
  int          low_runs[$];
  int          n_done;
  int          n_mr;
  logic        mr_at_done;

  task automatic set_start(input bit which, input logic v);
    if (which) start_b = v;
    else       start_a = v;
  endtask

  // Starts a run and monitors it to the done pulse plus a short tail.
  task automatic run(input bit which, input int busy_pulse_at, input bit pulse_in_fin);
    bit   seen    = 1'b0;
    logic prev_mr = 1'b0;
    logic mr, dn;
    int   low_run = 0;
    addrs.delete();
    low_runs.delete();
    n_done     = 0;
    n_mr       = 0;
    mr_at_done = 1'bx;
    set_start(which, 1'b1);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk);
      #1;
      set_start(which, c == busy_pulse_at);
      mr = which ? ifb.MemRead : ifa.MemRead;
      dn = which ? done_b : done_a;
      if (mr && !prev_mr) begin
        addrs.push_back(which ? ifb.address : ifa.address);
        if (low_run > 0) low_runs.push_back(low_run);
      end
      low_run = mr ? 0 : low_run + 1;
      if (mr) n_mr++;
      if (dn) begin
        n_done++;
        seen       = 1'b1;
        mr_at_done = mr;
      end
      prev_mr = mr;
    end
    check("run_reaches_done", 64'(seen), 64'd1);
    set_start(which, pulse_in_fin);
    repeat (3) begin
      @(posedge clk);
      #1;
      set_start(which, 1'b0);
      if (which ? done_b : done_a) n_done++;
      if (which ? ifb.MemRead : ifa.MemRead) n_mr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr_a", 64'(ifa.address), 64'h0);
    check("rst_addr_b", 64'(ifb.address), 64'h7FFE);
    check("rst_mr_a", 64'(ifa.MemRead), 64'd0);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_terr_a", 64'(terr_a), 64'd0);
    check("rst_counts_a", {hit_a, miss_a, sum_a}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Addr 0 misses with a 5-cycle stall, 1..3 hit; data = addr + 1
    miss_addr_a = 15'h0;
    delay_a     = 5;
    run(1'b0, -1, 1'b0);
    check("t2_hits", 64'(hit_a), 64'd3);
    check("t2_miss", 64'(miss_a), 64'd1);
    check("t2_sum", 64'(sum_a), 64'd10);
    check("t2_done_pulses", 64'(n_done), 64'd1);
    check("t2_mr_cycles", 64'(n_mr), 64'd9);
    check("t2_n_addrs", 64'(addrs.size()), 64'd4);
    if (addrs.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("t2_addr%0d", i), 64'(addrs[i]), 64'(i));
    end
    check("t2_busy_after", 64'(busy_a), 64'd0);

    // Dead memory: timeout after 8 WAIT cycles; extra starts during busy and FIN are ignored
    never_a = 1'b1;
    run(1'b0, 2, 1'b1);
    check("t4_terr", 64'(terr_a), 64'd1);
    check("t4_mr_at_done", 64'(mr_at_done), 64'd0);
    check("t4_mr_cycles", 64'(n_mr), 64'd9);
    check("t4_done_pulses", 64'(n_done), 64'd1);
    check("t4_counts", {hit_a, miss_a, sum_a}, 64'd0);
    check("t5_idle_after_fin_start", 64'(busy_a), 64'd0);

    // Wrapping sum, single-cycle gap, and start clearing timeout_err
    never_a     = 1'b0;
    ff_mode_a   = 1'b1;
    miss_addr_a = 15'h7FFF;
    run(1'b0, -1, 1'b0);
    check("t5_terr_cleared", 64'(terr_a), 64'd0);
    check("t6_sum_wrap", 64'(sum_a), 64'hFFFF_FFFE);
    check("t6_hits", 64'(hit_a), 64'd4);
    check("t6_miss", 64'(miss_a), 64'd0);
    check("t6_n_gaps", 64'(low_runs.size()), 64'd3);
    if (low_runs.size() > 0) check("t6_gap_len", 64'(low_runs[0]), 64'd1);

    // Address wrap on instance B
    run(1'b1, -1, 1'b0);
    check("t3_n_addrs", 64'(addrs.size()), 64'd3);
    if (addrs.size() == 3) begin
      check("t3_addr0", 64'(addrs[0]), 64'h7FFE);
      check("t3_addr1", 64'(addrs[1]), 64'h7FFF);
      check("t3_addr2", 64'(addrs[2]), 64'h0000);
    end
    check("t3_hits", 64'(hit_b), 64'd3);
    check("t3_sum", 64'(sum_b), 64'hFFFD);

    // Reset in cycle 3 of a stalled miss at 0x7FFF after one hit
    stall_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t1_pre_mr", 64'(ifb.MemRead), 64'd1);
    check("t1_pre_addr", 64'(ifb.address), 64'h7FFF);
    check("t1_pre_hits", 64'(hit_b), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_mr_dropped", 64'(ifb.MemRead), 64'd0);
    check("t1_addr", 64'(ifb.address), 64'h7FFE);
    check("t1_counts", {hit_b, miss_b, sum_b}, 64'd0);
    check("t1_busy", 64'(busy_b), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t1_stays_idle", 64'(ifb.MemRead), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
